// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory initiator for the core. It accepts one load/store request at a
//   time over a valid/ready handshake and performs byte/halfword/word accesses
//   on a little-endian, word-wide memory. Loads are sign- or zero-extended.
//   Sub-word stores are done as read-modify-write. Misaligned, out-of-range
//   and unsupported-funct3 requests complete with resp_error and do not touch
//   memory.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   req_valid/ready    request handshake (ready only while IDLE)
//   req_write          1 = store, 0 = load
//   req_funct3         RISC-V funct3 (0 B, 1 H, 2 W, 4 BU, 5 HU)
//   req_addr           byte address
//   req_wdata          store data (low bytes used for B/H)
//   resp_valid         one-cycle completion pulse
//   resp_rdata         extended load data, held until the next load response
//   resp_error         request rejected (qualifies resp_valid)
//   mem_address        word-aligned memory address (0 when not accessing)
//   mem_write_data     merged store word (0 outside the write cycle)
//   mem_write_enable   one-cycle write strobe
//   mem_read_data      combinational memory read word
module load_store_unit #(
    parameter int unsigned ADDR_LIMIT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rword_q;
    logic        err_q;

    logic        accept_err;
    logic        funct3_bad;
    logic        misaligned;
    logic        out_of_range;
    logic [32:0] end_addr;
    logic [31:0] lane_data;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Request validation on the live inputs; the result is captured together
    // with the request on the acceptance edge.
    always_comb begin
        // NOTE: every signal written in a combinational block is given a
        // default first so no path leaves it unassigned (no latch).
        funct3_bad   = 1'b0;
        misaligned   = 1'b0;
        if (req_write)
            funct3_bad = !(req_funct3 inside {3'd0, 3'd1, 3'd2});
        else
            funct3_bad = !(req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if ((req_funct3 == 3'd1 || req_funct3 == 3'd5) && req_addr[0])
            misaligned = 1'b1;
        if (req_funct3 == 3'd2 && req_addr[1:0] != 2'b00)
            misaligned = 1'b1;
        // 33-bit sum so an address near the top of the space cannot wrap
        // around and pass the limit check.
        end_addr     = {1'b0, req_addr[31:2], 2'b00} + 33'd4;
        out_of_range = end_addr > 33'(ADDR_LIMIT);
        accept_err   = funct3_bad || misaligned || out_of_range;
    end

    // Load lane select and extension from the live memory word.
    always_comb begin
        lane_data = mem_read_data >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'd0:    load_ext = {{24{lane_data[7]}}, lane_data[7:0]};
            3'd1:    load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
            3'd4:    load_ext = {24'd0, lane_data[7:0]};
            3'd5:    load_ext = {16'd0, lane_data[15:0]};
            default: load_ext = mem_read_data;
        endcase
    end

    // Store merge: replace the addressed lane(s) of the word read in READ.
    always_comb begin
        merged = rword_q;
        case (funct3_q[1:0])
            2'd0:    merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'd1:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every datapath register is reset as well as the state, so the
        // outputs built from them are defined from the first cycle.
        if (rst) begin
            state      <= S_IDLE;
            write_q    <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rword_q    <= 32'd0;
            err_q      <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        err_q    <= accept_err;
                        state    <= accept_err ? S_RESP : S_READ;
                    end
                end
                S_READ: begin
                    if (write_q) begin
                        rword_q <= mem_read_data;
                        state   <= S_WRITE;
                    end else begin
                        resp_rdata <= load_ext;
                        state      <= S_RESP;
                    end
                end
                S_WRITE: state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from state so an asynchronous reset removes the
    // write strobe and the response immediately.
    assign req_ready        = (state == S_IDLE) && !rst;
    assign resp_valid       = (state == S_RESP);
    assign resp_error       = (state == S_RESP) && err_q;
    assign mem_write_enable = (state == S_WRITE);
    assign mem_address      = (state == S_READ || state == S_WRITE) ?
                              {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_write_data   = (state == S_WRITE) ? merged : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];

    load_store_unit #(.ADDR_LIMIT(4096)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge.
    assign mem_read_data = mem[mem_address[11:2]];
    always @(posedge clk) begin
        if (mem_write_enable)
            mem[mem_address[11:2]] <= mem_write_data;
    end

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic exp_err,
                                input logic [31:0] exp_rdata, input int exp_lat,
                                input logic [31:0] exp_wdata);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_err = exp_err;
        v.exp_rdata = exp_rdata; v.exp_lat = exp_lat; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    // Issue one request (called at a negedge) and observe it to completion.
    task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic err,
                           output logic [31:0] rdata, output int wr_cnt,
                           output logic [31:0] wr_addr, output logic [31:0] wr_data,
                           output int addr_bad, output int ready_bad, output logic pulse_after);
        int guard;
        lat = 0; err = 1'b0; rdata = 32'd0; wr_cnt = 0; wr_addr = 32'd0; wr_data = 32'd0;
        addr_bad = 0; ready_bad = 0; pulse_after = 1'b0;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (req_ready) ready_bad++;
            if (mem_write_enable) begin
                wr_cnt++;
                wr_addr = mem_address;
                wr_data = mem_write_data;
            end else if (resp_valid) begin
                if (mem_address != 32'd0 || mem_write_data != 32'd0) addr_bad++;
                lat = cyc; err = resp_error; rdata = resp_rdata;
                break;
            end else if (mem_address != {addr[31:2], 2'b00}) begin
                addr_bad++;
            end
        end
        @(negedge clk);
        pulse_after = resp_valid;
        if (!req_ready) ready_bad++;
    endtask

    initial begin
        int          lat, wr_cnt, addr_bad, ready_bad;
        logic        err, pulse_after;
        logic [31:0] rdata, wr_addr, wr_data, saved;
        string       tag;

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[4] = 32'h88776655;

        //               wr  f3  addr          wdata         err  rdata         lat write-data
        vecs.push_back(mk(0, 0, 32'h13,       32'h0,        0, 32'hFFFFFF88, 2, 32'h0));
        vecs.push_back(mk(0, 4, 32'h13,       32'h0,        0, 32'h00000088, 2, 32'h0));
        vecs.push_back(mk(0, 1, 32'h12,       32'h0,        0, 32'hFFFF8877, 2, 32'h0));
        vecs.push_back(mk(0, 5, 32'h12,       32'h0,        0, 32'h00008877, 2, 32'h0));
        vecs.push_back(mk(0, 2, 32'h10,       32'h0,        0, 32'h88776655, 2, 32'h0));
        vecs.push_back(mk(1, 0, 32'h11,       32'hDEADBEAB, 0, 32'h88776655, 3, 32'h8877AB55));
        vecs.push_back(mk(0, 2, 32'h10,       32'h0,        0, 32'h8877AB55, 2, 32'h0));
        vecs.push_back(mk(1, 2, 32'h10,       32'h88776655, 0, 32'h8877AB55, 3, 32'h88776655));
        vecs.push_back(mk(1, 1, 32'h12,       32'h00001234, 0, 32'h8877AB55, 3, 32'h12346655));
        vecs.push_back(mk(0, 2, 32'h10,       32'h0,        0, 32'h12346655, 2, 32'h0));
        vecs.push_back(mk(1, 2, 32'h10,       32'hCAFEF00D, 0, 32'h12346655, 3, 32'hCAFEF00D));
        vecs.push_back(mk(0, 2, 32'h10,       32'h0,        0, 32'hCAFEF00D, 2, 32'h0));
        vecs.push_back(mk(0, 2, 32'h12,       32'h0,        1, 32'hCAFEF00D, 1, 32'h0));
        vecs.push_back(mk(0, 1, 32'h11,       32'h0,        1, 32'hCAFEF00D, 1, 32'h0));
        vecs.push_back(mk(0, 3, 32'h10,       32'h0,        1, 32'hCAFEF00D, 1, 32'h0));
        vecs.push_back(mk(1, 2, 32'h1000,     32'h5555AAAA, 1, 32'hCAFEF00D, 1, 32'h0));
        vecs.push_back(mk(0, 2, 32'hFFFFFFFC, 32'h0,        1, 32'hCAFEF00D, 1, 32'h0));
        vecs.push_back(mk(1, 4, 32'h10,       32'h11111111, 1, 32'hCAFEF00D, 1, 32'h0));
        vecs.push_back(mk(1, 1, 32'h13,       32'h22222222, 1, 32'hCAFEF00D, 1, 32'h0));
        vecs.push_back(mk(0, 7, 32'h10,       32'h0,        1, 32'hCAFEF00D, 1, 32'h0));
        vecs.push_back(mk(1, 2, 32'hFFC,      32'h11223344, 0, 32'hCAFEF00D, 3, 32'h11223344));
        vecs.push_back(mk(0, 0, 32'hFFF,      32'h0,        0, 32'h00000011, 2, 32'h0));
        vecs.push_back(mk(0, 0, 32'h12,       32'h0,        0, 32'hFFFFFFFE, 2, 32'h0));
        vecs.push_back(mk(0, 1, 32'h10,       32'h0,        0, 32'hFFFFF00D, 2, 32'h0));
        vecs.push_back(mk(0, 4, 32'h10,       32'h0,        0, 32'h0000000D, 2, 32'h0));
        vecs.push_back(mk(0, 0, 32'h1000,     32'h0,        1, 32'h0000000D, 1, 32'h0));

        // Reset state.
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check("rst_mem_we", 32'(mem_write_enable), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        foreach (vecs[i]) begin
            run_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    lat, err, rdata, wr_cnt, wr_addr, wr_data, addr_bad, ready_bad, pulse_after);
            tag = $sformatf("v%0d", i);
            check({tag, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({tag, "_error"}, 32'(err), 32'(vecs[i].exp_err));
            check({tag, "_rdata"}, rdata, vecs[i].exp_rdata);
            check({tag, "_addr_drive"}, 32'(addr_bad), 32'd0);
            check({tag, "_ready_busy"}, 32'(ready_bad), 32'd0);
            check({tag, "_single_pulse"}, 32'(pulse_after), 32'd0);
            if (vecs[i].wr && !vecs[i].exp_err) begin
                check({tag, "_write_count"}, 32'(wr_cnt), 32'd1);
                check({tag, "_write_addr"}, wr_addr, {vecs[i].addr[31:2], 2'b00});
                check({tag, "_write_data"}, wr_data, vecs[i].exp_wdata);
            end else begin
                check({tag, "_no_write"}, 32'(wr_cnt), 32'd0);
            end
        end

        // Reset in the WRITE cycle of SB 0x10: write must be suppressed.
        saved = mem[4];
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h10; req_wdata = 32'h000000AA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 check("abort_we_before", 32'(mem_write_enable), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_we_dropped", 32'(mem_write_enable), 32'd0);
        check("abort_ready_in_rst", 32'(req_ready), 32'd0);
        check("abort_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("abort_no_resp2", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(req_ready), 32'd1);
        check("abort_mem_unchanged", mem[4], saved);
        @(negedge clk);
        check("abort_no_resp3", 32'(resp_valid), 32'd0);
        run_req(1'b0, 3'd2, 32'h10, 32'h0, lat, err, rdata, wr_cnt, wr_addr, wr_data,
                addr_bad, ready_bad, pulse_after);
        check("abort_lw_latency", 32'(lat), 32'd2);
        check("abort_lw_rdata", rdata, saved);
        check("abort_lw_error", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
